decod7s_varredura: RTL and testbench

Scan-side decoder for the multiplexed 7-segment display path. It watches the active-low segment bus and the one-hot digit-select lines driven to the display. For each digit it waits until the pattern has been stable long enough, decodes it back to BCD, and assembles a full multi-digit frame. It sits alongside the display driver for loopback self-check and for reading back what the panel shows.

---
 rtl/decod7s_varredura.sv | 127 ++++++++++++
 tb/tb_decod7s_varredura.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/decod7s_varredura.sv
// Scan-side 7-segment decoder: waits for each multiplexed digit to settle,
// decodes the active-low pattern back to BCD and assembles a full frame.
module decod7s_varredura #(
    parameter int N_DIGITOS = 4,
    parameter int ESTAVEL   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6:0]             segmentos,
    input  logic [N_DIGITOS-1:0]   digito_sel,
    output logic [4*N_DIGITOS-1:0] numeros,
    output logic [N_DIGITOS-1:0]   invalido,
    output logic                   quadro_valido,
    output logic                   erro_sel
);

    typedef enum logic {IDLE, COLETANDO} estado_t;

    estado_t                  estado;
    logic [N_DIGITOS-1:0]     sel_ant;
    logic [6:0]               seg_ant;
    logic [7:0]               cont;
    logic [N_DIGITOS-1:0]     mask;
    logic [4*N_DIGITOS-1:0]   sombra_num;
    logic [N_DIGITOS-1:0]     sombra_inv;

    int unsigned              nbits;
    logic                     um_quente;
    logic                     varios;
    logic [7:0]               cont_prox;
    logic                     captura;
    logic                     completo;
    logic [3:0]               dec_num;
    logic                     dec_inv;
    logic [N_DIGITOS-1:0]     mask_prox;
    logic [4*N_DIGITOS-1:0]   sombra_num_prox;
    logic [N_DIGITOS-1:0]     sombra_inv_prox;

    // Decode the active-low segment pattern to a nibble plus invalid flag
    always_comb begin
        dec_num = 4'hE;
        dec_inv = 1'b1;
        case (segmentos)
            7'h40: begin dec_num = 4'd0; dec_inv = 1'b0; end
            7'h79: begin dec_num = 4'd1; dec_inv = 1'b0; end
            7'h24: begin dec_num = 4'd2; dec_inv = 1'b0; end
            7'h30: begin dec_num = 4'd3; dec_inv = 1'b0; end
            7'h19: begin dec_num = 4'd4; dec_inv = 1'b0; end
            7'h12: begin dec_num = 4'd5; dec_inv = 1'b0; end
            7'h02: begin dec_num = 4'd6; dec_inv = 1'b0; end
            7'h78: begin dec_num = 4'd7; dec_inv = 1'b0; end
            7'h00: begin dec_num = 4'd8; dec_inv = 1'b0; end
            7'h10: begin dec_num = 4'd9; dec_inv = 1'b0; end
            7'h7F: begin dec_num = 4'hF; dec_inv = 1'b0; end
            default: begin dec_num = 4'hE; dec_inv = 1'b1; end
        endcase
    end

    // Stability counting, capture decision and next shadow/mask contents
    always_comb begin
        nbits = 0;
        for (int unsigned i = 0; i < N_DIGITOS; i++)
            nbits = nbits + 32'(digito_sel[i]);
        um_quente = (nbits == 1);
        varios    = (nbits > 1);

        cont_prox = 8'd0;
        if (um_quente) begin
            // a one-hot sample equal to the previous one implies the previous
            // sample was also one-hot, so the run simply continues
            if (digito_sel == sel_ant && segmentos == seg_ant)
                cont_prox = (cont == 8'(ESTAVEL)) ? cont : cont + 8'd1;
            else
                cont_prox = 8'd1;
        end
        captura = um_quente && (cont_prox == 8'(ESTAVEL)) && (cont != 8'(ESTAVEL));

        sombra_num_prox = sombra_num;
        sombra_inv_prox = sombra_inv;
        mask_prox       = (estado == IDLE) ? '0 : mask;
        if (captura) begin
            mask_prox = mask_prox | digito_sel;
            for (int unsigned i = 0; i < N_DIGITOS; i++) begin
                if (digito_sel[i]) begin
                    sombra_num_prox[4*i +: 4] = dec_num;
                    sombra_inv_prox[i]        = dec_inv;
                end
            end
        end
        completo = captura && (mask_prox == '1);
    end

    // Registered state and outputs; frame completion publishes the shadow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado        <= IDLE;
            sel_ant       <= '0;
            seg_ant       <= '0;
            cont          <= 8'd0;
            mask          <= '0;
            sombra_num    <= '1;
            sombra_inv    <= '0;
            numeros       <= '1;
            invalido      <= '0;
            quadro_valido <= 1'b0;
            erro_sel      <= 1'b0;
        end else begin
            sel_ant       <= digito_sel;
            seg_ant       <= segmentos;
            cont          <= cont_prox;
            sombra_num    <= sombra_num_prox;
            sombra_inv    <= sombra_inv_prox;
            erro_sel      <= varios;
            quadro_valido <= completo;
            if (completo) begin
                numeros  <= sombra_num_prox;
                invalido <= sombra_inv_prox;
                mask     <= '0;
                estado   <= IDLE;
            end else begin
                mask   <= mask_prox;
                estado <= (mask_prox != '0) ? COLETANDO : IDLE;
            end
        end
    end

endmodule

// File: tb/tb_decod7s_varredura.sv
// Bench for decod7s_varredura: table-driven frames, directed corner cases and
// randomized scanning checked cycle by cycle against a reference model.
module tb_decod7s_varredura;

    localparam int N = 4;
    localparam int E = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [6:0]     segmentos = 7'h7F;
    logic [N-1:0]   digito_sel = '0;
    logic [4*N-1:0] numeros;
    logic [N-1:0]   invalido;
    logic           quadro_valido;
    logic           erro_sel;

    decod7s_varredura #(.N_DIGITOS(N), .ESTAVEL(E)) dut (
        .clk(clk), .reset(reset), .segmentos(segmentos), .digito_sel(digito_sel),
        .numeros(numeros), .invalido(invalido),
        .quadro_valido(quadro_valido), .erro_sel(erro_sel)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int qv_count = 0;
    int err_count = 0;

    // reference model state
    logic [10:0]    hist[$];
    logic [3:0]     m_shadow[N];
    logic           m_shinv[N];
    bit             m_got[N];
    logic [4*N-1:0] exp_num;
    logic [N-1:0]   exp_inv;
    logic           exp_qv;
    logic           exp_err;

    logic [6:0] pats[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_decode(input logic [6:0] s, output logic [3:0] v, output logic inv);
        v = 4'hE; inv = 1'b1;
        if (s == 7'h7F) begin v = 4'hF; inv = 1'b0; end
        for (int k = 0; k < 10; k++)
            if (pats[k] == s) begin v = 4'(k); inv = 1'b0; end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < N; k++) begin m_shadow[k] = 4'hF; m_shinv[k] = 1'b0; m_got[k] = 0; end
        exp_num = '1; exp_inv = '0; exp_qv = 1'b0; exp_err = 1'b0;
    endtask

    // Model: a capture happens when the last E samples are the same one-hot
    // pair and the sample before them (if any) was different.
    task automatic model_step(input logic [N-1:0] sel, input logic [6:0] seg);
        bit cap, all;
        int sz, d;
        logic [3:0] v;
        logic inv;
        hist.push_back({sel, seg});
        if (hist.size() > E + 1) void'(hist.pop_front());
        sz = hist.size();
        exp_err = ($countones(sel) > 1);
        exp_qv = 1'b0;
        cap = ($countones(sel) == 1) && (sz >= E);
        if (cap) begin
            for (int k = sz - E; k < sz; k++)
                if (hist[k] != hist[sz-1]) cap = 0;
            if (sz > E && hist[sz-E-1] == hist[sz-1]) cap = 0;
        end
        if (cap) begin
            d = 0;
            for (int k = 0; k < N; k++) if (sel[k]) d = k;
            model_decode(seg, v, inv);
            m_shadow[d] = v; m_shinv[d] = inv; m_got[d] = 1;
            all = 1;
            for (int k = 0; k < N; k++) if (!m_got[k]) all = 0;
            if (all) begin
                for (int k = 0; k < N; k++) begin
                    exp_num[4*k +: 4] = m_shadow[k];
                    exp_inv[k] = m_shinv[k];
                    m_got[k] = 0;
                end
                exp_qv = 1'b1;
            end
        end
    endtask

    task automatic step(input logic [N-1:0] sel, input logic [6:0] seg);
        digito_sel = sel;
        segmentos  = seg;
        @(posedge clk);
        model_step(sel, seg);
        #1;
        if (quadro_valido === 1'b1) qv_count++;
        if (erro_sel === 1'b1) err_count++;
        check("numeros", 32'(numeros), 32'(exp_num));
        check("invalido", 32'(invalido), 32'(exp_inv));
        check("quadro_valido", 32'(quadro_valido), 32'(exp_qv));
        check("erro_sel", 32'(erro_sel), 32'(exp_err));
    endtask

    task automatic scan(input int d, input logic [6:0] seg, input int dwell);
        logic [N-1:0] s;
        s = '0;
        s[d] = 1'b1;
        for (int k = 0; k < dwell; k++) step(s, seg);
        step('0, 7'h7F);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_numeros", 32'(numeros), 32'hFFFF);
        check("rst_invalido", 32'(invalido), 32'h0);
        check("rst_qv", 32'(quadro_valido), 32'h0);
        check("rst_erro", 32'(erro_sel), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [6:0] seg;
        logic [3:0] nib;
        logic       inv;
    } vec_t;

    vec_t tbl[12];
    int q0, e0;
    logic [3:0] rnib;

    initial begin
        tbl[0]  = '{7'h40, 4'd0, 1'b0}; tbl[1]  = '{7'h79, 4'd1, 1'b0};
        tbl[2]  = '{7'h24, 4'd2, 1'b0}; tbl[3]  = '{7'h30, 4'd3, 1'b0};
        tbl[4]  = '{7'h19, 4'd4, 1'b0}; tbl[5]  = '{7'h12, 4'd5, 1'b0};
        tbl[6]  = '{7'h02, 4'd6, 1'b0}; tbl[7]  = '{7'h78, 4'd7, 1'b0};
        tbl[8]  = '{7'h00, 4'd8, 1'b0}; tbl[9]  = '{7'h10, 4'd9, 1'b0};
        tbl[10] = '{7'h7E, 4'hE, 1'b1}; tbl[11] = '{7'h7F, 4'hF, 1'b0};

        model_reset();
        #3;
        do_reset();

        // normal frame
        q0 = qv_count;
        scan(0, 7'h79, 6); scan(1, 7'h24, 6); scan(2, 7'h30, 6); scan(3, 7'h19, 6);
        check("normal_numeros", 32'(numeros), 32'h4321);
        check("normal_invalido", 32'(invalido), 32'h0);
        check("normal_qv_pulses", 32'(qv_count - q0), 32'd1);

        // table-driven frames: three frames of four digits
        for (int f = 0; f < 3; f++) begin
            for (int d = 0; d < N; d++) scan(d, tbl[4*f+d].seg, 5);
            for (int d = 0; d < N; d++) begin
                rnib = numeros[4*d +: 4];
                check("tbl_nibble", 32'(rnib), 32'(tbl[4*f+d].nib));
                check("tbl_inv", 32'(invalido[d]), 32'(tbl[4*f+d].inv));
            end
        end

        // invalid and blank patterns
        scan(0, 7'h40, 6); scan(1, 7'h7E, 6); scan(2, 7'h12, 6); scan(3, 7'h7F, 6);
        check("invblank_numeros", 32'(numeros), 32'hF5E0);
        check("invblank_invalido", 32'(invalido), 32'b0010);

        // glitch rejection: short dwell of 0x40 on digit 2 must not capture
        scan(0, 7'h79, 6); scan(1, 7'h24, 6); scan(2, 7'h24, 6); scan(3, 7'h30, 6);
        scan(0, 7'h02, 6); scan(1, 7'h78, 6); scan(2, 7'h40, 3);
        q0 = qv_count;
        scan(3, 7'h00, 6);
        check("glitch_no_frame", 32'(qv_count - q0), 32'd0);
        scan(2, 7'h24, 6);
        check("glitch_numeros", 32'(numeros), 32'h8276);

        // select error: digits 0,1 captured, then two-hot select held
        scan(0, 7'h19, 6); scan(1, 7'h12, 6);
        q0 = qv_count; e0 = err_count;
        for (int k = 0; k < 6; k++) step(4'b0011, 7'h40);
        step('0, 7'h7F);
        check("sel_err_pulses", 32'(err_count - e0), 32'd6);
        check("sel_err_no_frame", 32'(qv_count - q0), 32'd0);
        scan(2, 7'h10, 6); scan(3, 7'h40, 6);
        check("sel_err_mask_kept", 32'(numeros), 32'h0954);

        // reset mid-frame
        scan(0, 7'h02, 6); scan(1, 7'h02, 6);
        step(4'b0100, 7'h78);
        do_reset();
        check("midrst_numeros", 32'(numeros), 32'hFFFF);
        q0 = qv_count;
        scan(2, 7'h30, 6); scan(3, 7'h12, 6); scan(0, 7'h79, 6);
        check("midrst_no_early", 32'(qv_count - q0), 32'd0);
        scan(1, 7'h00, 6);
        check("midrst_one_frame", 32'(qv_count - q0), 32'd1);
        check("midrst_numeros_new", 32'(numeros), 32'h5381);

        // randomized scanning against the model
        for (int ev = 0; ev < 300; ev++) begin
            int kind, dwell;
            logic [N-1:0] s;
            logic [6:0] g;
            kind  = int'($urandom_range(0, 9));
            dwell = int'($urandom_range(1, 7));
            s = '0;
            if (kind == 1) begin
                s = 4'(1 << $urandom_range(0, 3)) | 4'(1 << $urandom_range(0, 3));
                if ($countones(s) < 2) s = 4'b1001;
            end else if (kind > 1) begin
                s[$urandom_range(0, 3)] = 1'b1;
            end
            g = ($urandom_range(0, 9) < 8) ? tbl[$urandom_range(0, 11)].seg : 7'($urandom);
            for (int k = 0; k < dwell; k++) step(s, g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
